// File: rtl/pad_cond_pkg.sv
// Shared types, defaults and helpers for the pad input conditioner.
// The per-channel debounce FSM has only two states, so it is a one-bit enum.
package pad_cond_pkg;

  typedef enum logic {
    DBNC_STABLE  = 1'b0,
    DBNC_PENDING = 1'b1
  } dbnc_state_e;

  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Counter width able to hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input channel: synchroniser chain, debounce FSM/counter,
// and registered level plus rise/fall strobes.
module debounce_channel
  import pad_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  input  logic sample_en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stable
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  dbnc_state_e            state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   level_r, level_s;
  logic                   rise_r, rise_s;
  logic                   fall_r, fall_s;
  logic                   mismatch_s;
  logic                   at_limit_s;

  assign sync_s     = sync_r[SYNC_STAGES-1];
  assign mismatch_s = (sync_s != level_r);
  assign at_limit_s = (cnt_r == CNT_LAST);

  // Plain flop chain; stage 0 is the only flop that sees the asynchronous pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
    end
  end

  // Debounce next-state: a sampled mismatch counts even from STABLE, so the
  // acceptance lands exactly DEBOUNCE_CYCLES samples after sync changes.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    case (state_r)
      DBNC_STABLE: begin
        if (mismatch_s) begin
          if (sample_en) begin
            if (at_limit_s) begin
              level_s = ~level_r;
              cnt_s   = '0;
              state_s = DBNC_STABLE;
              rise_s  = ~level_r;
              fall_s  = level_r;
            end else begin
              cnt_s   = cnt_r + CNT_W'(1);
              state_s = DBNC_PENDING;
            end
          end else begin
            state_s = DBNC_PENDING;
          end
        end else begin
          cnt_s = '0;
        end
      end
      DBNC_PENDING: begin
        if (!mismatch_s) begin
          cnt_s   = '0;
          state_s = DBNC_STABLE;
        end else if (sample_en) begin
          if (at_limit_s) begin
            level_s = ~level_r;
            cnt_s   = '0;
            state_s = DBNC_STABLE;
            rise_s  = ~level_r;
            fall_s  = level_r;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = DBNC_STABLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter, level and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DBNC_STABLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
    end
  end

  assign level  = level_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign stable = (state_r == DBNC_STABLE);

endmodule

// File: rtl/pad_input_conditioner.sv
// Array of independent debounce channels between the pad buffers and the LUT
// stage, plus an all-channels-settled flag taken straight from state flops.
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pad_in,
  input  logic              sample_en,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              settled
);

  if (NUM_CH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("pad_input_conditioner: illegal parameters NUM_CH=%0d SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d",
           NUM_CH, SYNC_STAGES, DEBOUNCE_CYCLES);
  end

  logic [NUM_CH-1:0] stable_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .pad      (pad_in[g]),
      .sample_en(sample_en),
      .level    (level_out[g]),
      .rise     (rise_pulse[g]),
      .fall     (fall_pulse[g]),
      .stable   (stable_s[g])
    );
  end

  assign settled = &stable_s;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed + random bench for pad_input_conditioner: a default build and a
// DEBOUNCE_CYCLES=1 build share pad_in[0] and are checked against a run-length model.
module tb_pad_input_conditioner;

  localparam int SS  = 2;
  localparam int MCH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pad_in = 2'b00;
  logic       sample_en = 1'b1;
  logic [1:0] level_out, rise_pulse, fall_pulse;
  logic       settled;
  logic [0:0] level1, rise1, fall1;
  logic       settled1;

  int n_cmp = 0;
  int n_err = 0;

  // Model channels 0,1 -> default build; channel 2 -> DEBOUNCE_CYCLES=1 build on pad_in[0].
  int          md[MCH] = '{4, 4, 1};
  logic [SS-1:0] m_pipe[MCH];
  logic        m_lvl[MCH], m_rise[MCH], m_fall[MCH], m_pend[MCH];
  int          m_run[MCH];

  always #5 clk = ~clk;

  pad_input_conditioner u_dut (
    .clk(clk), .rst_n(rst_n), .pad_in(pad_in), .sample_en(sample_en),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .settled(settled)
  );

  pad_input_conditioner #(.NUM_CH(1), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pad_in(pad_in[0:0]), .sample_en(sample_en),
    .level_out(level1), .rise_pulse(rise1), .fall_pulse(fall1),
    .settled(settled1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < MCH; c++) begin
      m_pipe[c] = '0; m_lvl[c] = 1'b0; m_rise[c] = 1'b0;
      m_fall[c] = 1'b0; m_pend[c] = 1'b0; m_run[c] = 0;
    end
  endtask

  // A new level is accepted once md consecutive sampled sync values disagree with it.
  task automatic model_edge();
    logic s, p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < MCH; c++) begin
      s = m_pipe[c][SS-1];
      p = (c == 2) ? pad_in[0] : pad_in[c];
      m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_pend[c] = 1'b0;
      if (s == m_lvl[c]) begin
        m_run[c] = 0;
      end else if (sample_en) begin
        m_run[c]++;
        if (m_run[c] == md[c]) begin
          m_rise[c] = s; m_fall[c] = ~s; m_lvl[c] = s; m_run[c] = 0;
        end else begin
          m_pend[c] = 1'b1;
        end
      end else begin
        m_pend[c] = 1'b1;
      end
      m_pipe[c] = {m_pipe[c][SS-2:0], p};
    end
  endtask

  task automatic check_all();
    chk("level_out", 32'(level_out), 32'({m_lvl[1], m_lvl[0]}));
    chk("rise_pulse", 32'(rise_pulse), 32'({m_rise[1], m_rise[0]}));
    chk("fall_pulse", 32'(fall_pulse), 32'({m_fall[1], m_fall[0]}));
    chk("settled", 32'(settled), 32'(!(m_pend[0] || m_pend[1])));
    chk("rise_fall_excl", 32'(rise_pulse & fall_pulse), 32'd0);
    chk("d1_level", 32'(level1), 32'(m_lvl[2]));
    chk("d1_rise", 32'(rise1), 32'(m_rise[2]));
    chk("d1_fall", 32'(fall1), 32'(m_fall[2]));
    chk("d1_settled", 32'(settled1), 32'(!m_pend[2]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset_check();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_level", 32'(level_out), 32'd0);
    chk("rst_async_rise", 32'(rise_pulse), 32'd0);
    chk("rst_async_fall", 32'(fall_pulse), 32'd0);
    chk("rst_async_settled", 32'(settled), 32'd1);
    chk("rst_async_d1_level", 32'(level1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    ticks(3);
    check_all();

    // Reset exit with pads high: both channels rise after full latency.
    @(negedge clk);
    pad_in = 2'b11;
    rst_n  = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (level_out == 2'b11) break;
    end
    chk("latency_edges", 32'(n), 32'd6);
    ticks(3);

    // Asynchronous reset in mid-cycle with pads still high, then re-acquire.
    async_reset_check();
    ticks(10);

    // Return both low, then a clean 0->1 on ch0 only.
    pad_in = 2'b00;
    ticks(10);
    pad_in = 2'b01;
    ticks(10);

    // Glitch on ch1: three cycles high then low.
    pad_in = 2'b11;
    ticks(3);
    pad_in = 2'b01;
    ticks(8);

    // Bring ch1 high, then drop it while sampling only every third cycle.
    pad_in = 2'b11;
    ticks(10);
    pad_in = 2'b01;
    for (int i = 0; i < 24; i++) begin
      sample_en = (i % 3 == 0);
      tick();
    end
    sample_en = 1'b1;
    ticks(4);

    // Opposite simultaneous transitions: ch0 1->0 ... first set 01, then 10.
    pad_in = 2'b10;
    ticks(10);

    // Reset with ch0 mid-pending (two samples counted), then pads low.
    pad_in = 2'b11;
    ticks(4);
    async_reset_check();
    pad_in = 2'b00;
    ticks(10);

    // Randomised pad activity with every-cycle sampling.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) pad_in = 2'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pad_input_conditioner.md
Name: pad_input_conditioner

Overview:
Per-channel input conditioner that sits directly upstream of the LUT logic stage, between the input pad buffers and the combinational fabric logic. Each asynchronous pad input is synchronised, debounced, and edge-detected. Downstream logic receives clean registered levels plus single-cycle rise/fall strobes. Used in the FF/LUT feature designs wherever a pad input feeds logic.

Parameters:
NUM_CH, 2, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 4, consecutive mismatching samples required to accept a new level (>=1)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
pad_in  in  NUM_CH  raw inputs from the input pad buffers; asynchronous to clk
sample_en  in  1  debounce sampling tick; tie high to sample every cycle
level_out  out  NUM_CH  debounced level per channel, fed to the LUT stage
rise_pulse  out  NUM_CH  1-cycle strobe when level_out goes 0->1
fall_pulse  out  NUM_CH  1-cycle strobe when level_out goes 1->0
settled  out  1  high when every channel is in STABLE state

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. Every flop clears immediately on rst_n=0, independent of clk.
- Reset values: sync chain 0, level_out 0, rise_pulse 0, fall_pulse 0, counters 0, all channel FSMs in STABLE, settled 1.
- Synchroniser: SYNC_STAGES flops per channel. sync[ch] = last stage. No logic between stages.
- Per-channel FSM:
  - STABLE: sync==level_out. Counter held at 0. Go to PENDING when sync!=level_out.
  - PENDING: on each cycle with sample_en=1 and sync!=level_out, counter increments.
  - PENDING, sample matches level_out (glitch): counter clears to 0 and FSM returns to STABLE. No output change.
  - PENDING, sample_en=0: counter and state hold.
  - Accept: when sample_en=1, sync!=level_out and counter==DEBOUNCE_CYCLES-1, then on that edge level_out toggles, counter clears, FSM returns to STABLE, and the matching rise/fall pulse asserts for exactly that one following cycle.
- Latency with sample_en tied high and pad held steady: level_out changes exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first edge that samples the new pad value. For defaults this is 6 edges.
- DEBOUNCE_CYCLES=1: accept on the first mismatching sample; the counter is never nonzero.
- Pulses: rise_pulse and fall_pulse are never high together on one channel. Both are registered outputs (no combinational path from pad_in).
- Channels are fully independent. Simultaneous accepts on several channels each produce their own pulse in the same cycle.
- settled = AND over channels of (state==STABLE); registered-equivalent, derived from state flops only.
- Reset mid-PENDING: the in-flight transition is discarded, and no pulse is emitted on reset exit.
- Reset exit: a pad held at 1 is treated as a normal 0->1 transition. rise_pulse fires after the full latency.
- Counter saturation cannot occur: accept fires at DEBOUNCE_CYCLES-1, and CNT_W covers that value.
- Elaboration-time error if SYNC_STAGES<2, DEBOUNCE_CYCLES<1 or NUM_CH<1.

Decomposition:
- Shared package pad_cond_pkg:
  - state enum dbnc_state_e {DBNC_STABLE, DBNC_PENDING}
  - function cnt_width(int n) returning $clog2(n+1)
  - default parameter constants
- Sub-module debounce_channel: one synchroniser + FSM + counter + pulse flops. Instantiated NUM_CH times via generate.
- Top level: generate loop plus the settled AND reduction.

Test Plan:
- Reset: assert rst_n=0 mid-clock with pad_in=2'b11 -> all outputs 0 and settled=1 immediately (asynchronous). Release, hold pad_in=2'b11 -> level_out=2'b11 after 6 edges; rise_pulse=2'b11 for 1 cycle; settled=0 during those 6 cycles.
- Clean transition: ch0 0->1 held, sample_en=1 -> level_out[0]=1 exactly 6 edges later; rise_pulse[0]=1 for one cycle; ch1 unaffected.
- Glitch rejection: ch0 high for 3 cycles then low -> level_out[0] stays 0; no pulses; settled returns to 1.
- sample_en gating: ch1 1->0 with sample_en pulsed every 3rd cycle -> fall_pulse[1] fires only after the 4th sampled mismatch, about 12 cycles after sync.
- Simultaneous: both channels toggle opposite directions on the same edge -> rise_pulse[0] and fall_pulse[1] in the same cycle; never rise and fall on one channel.
- Reset mid-PENDING: pull rst_n low with ch0 counter=2 -> counter 0, level_out 0, no pulse after release; DEBOUNCE_CYCLES=1 build accepts after SYNC_STAGES+1 edges.
